// File: rtl/kalman_pkg.sv
// Shared widths, FSM encoding and fixed-point helpers for the alpha-beta tracker.
package kalman_pkg;

  localparam int DISP_WIDTH = 11;
  localparam int NUM_CHAN   = 4;
  localparam int CHAN_W     = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam int FRAC       = 8;
  localparam int ALPHA_FI   = 128;
  localparam int BETA_FI    = 32;
  localparam int GATE_PX    = 64;
  localparam int MAX_MISS   = 3;
  localparam int SW         = DISP_WIDTH + FRAC + 2;
  localparam int MISS_W     = $clog2(MAX_MISS + 1);

  localparam logic signed [SW-1:0] DISP_MAX = SW'((2 ** DISP_WIDTH) - 1);
  localparam logic [SW-1:0]        GATE_LIM = SW'(GATE_PX * (2 ** FRAC));

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREDICT = 3'd1,
    ST_INNOV   = 3'd2,
    ST_UPDATE  = 3'd3,
    ST_OUTPUT  = 3'd4
  } state_e;

  // Drop the fraction (floor) and clamp into the displayable pixel range.
  function automatic logic [DISP_WIDTH-1:0] sat_to_disp(input logic signed [SW-1:0] p);
    logic signed [SW-1:0] q;
    q = p >>> FRAC;
    if (q[SW-1]) return {DISP_WIDTH{1'b0}};
    else if (q > DISP_MAX) return {DISP_WIDTH{1'b1}};
    else return q[DISP_WIDTH-1:0];
  endfunction

  function automatic logic [SW-1:0] abs_sw(input logic signed [SW-1:0] a);
    if (a[SW-1]) return -a;
    else return a;
  endfunction

endpackage

// File: rtl/kalman_ab_axis.sv
// One-axis alpha-beta datapath: registered predict and innovation, combinational update.
// KALMAN_GATE_EN enables the innovation-gate comparator; otherwise over_gate is tied low.
module kalman_ab_axis
  import kalman_pkg::*;
(
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  pred_en,
  input  logic                  innov_en,
  input  logic                  init_mode,
  input  logic                  hold,
  input  logic signed [SW-1:0]  p_in,
  input  logic signed [SW-1:0]  v_in,
  input  logic [DISP_WIDTH-1:0] z,
  output logic signed [SW-1:0]  p_new,
  output logic signed [SW-1:0]  v_new,
  output logic                  over_gate
);

  localparam logic signed [2*SW-1:0] ALPHA_W = (2*SW)'(ALPHA_FI);
  localparam logic signed [2*SW-1:0] BETA_W  = (2*SW)'(BETA_FI);

  logic signed [SW-1:0]   p_pred_r, v_r, r_r, z_fix_s, a_upd_s, b_upd_s;
  logic signed [2*SW-1:0] a_prod_s, b_prod_s;

  assign z_fix_s  = {{(SW-DISP_WIDTH-FRAC){1'b0}}, z, {FRAC{1'b0}}};
  assign a_prod_s = ALPHA_W * (2*SW)'(r_r);
  assign b_prod_s = BETA_W * (2*SW)'(r_r);
  assign a_upd_s  = SW'(a_prod_s >>> FRAC);
  assign b_upd_s  = SW'(b_prod_s >>> FRAC);

`ifdef KALMAN_GATE_EN
  assign over_gate = (abs_sw(r_r) > GATE_LIM);
`else
  assign over_gate = 1'b0;
`endif

  // Predicted position and innovation, each captured on its FSM strobe.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      p_pred_r <= {SW{1'b0}};
      v_r      <= {SW{1'b0}};
      r_r      <= {SW{1'b0}};
    end else begin
      if (pred_en) begin
        p_pred_r <= p_in + v_in;
        v_r      <= v_in;
      end
      if (innov_en) r_r <= z_fix_s - p_pred_r;
    end
  end

  // A rejected measurement coasts on the prediction; a fresh channel snaps to z.
  always_comb begin
    p_new = p_pred_r;
    v_new = v_r;
    if (init_mode) begin
      p_new = z_fix_s;
      v_new = {SW{1'b0}};
    end else if (hold) begin
      p_new = p_pred_r;
      v_new = v_r;
    end else begin
      p_new = p_pred_r + a_upd_s;
      v_new = v_r + b_upd_s;
    end
  end

endmodule

// File: rtl/kalman_ab_tracker.sv
// Multi-channel steady-state alpha-beta tracker: FSM, per-channel state, init bits.
// Define KALMAN_GATE_EN to add innovation gating with per-channel miss counters.
module kalman_ab_tracker
  import kalman_pkg::*;
(
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  chan_clr,
  input  logic [CHAN_W-1:0]     clr_chan,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CHAN_W-1:0]     in_chan,
  input  logic [DISP_WIDTH-1:0] z_x,
  input  logic [DISP_WIDTH-1:0] z_y,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CHAN_W-1:0]     out_chan,
  output logic [DISP_WIDTH-1:0] x_est,
  output logic [DISP_WIDTH-1:0] y_est,
  output logic                  out_rej
);

  state_e                state_r, state_s;
  logic                  accept_s, gate_s, drop_s, ox_s, oy_s;
  logic [CHAN_W-1:0]     cur_chan_r, out_chan_r;
  logic [DISP_WIDTH-1:0] zx_r, zy_r, x_est_r, y_est_r;
  logic                  cur_init_r, kill_r, in_ready_r, out_valid_r, out_rej_r;
  logic [NUM_CHAN-1:0]   init_r;
  logic signed [SW-1:0]  px_r [NUM_CHAN];
  logic signed [SW-1:0]  py_r [NUM_CHAN];
  logic signed [SW-1:0]  vx_r [NUM_CHAN];
  logic signed [SW-1:0]  vy_r [NUM_CHAN];
  logic signed [SW-1:0]  px_new_s, py_new_s, vx_new_s, vy_new_s;

  assign accept_s  = in_valid && in_ready_r;
  assign gate_s    = cur_init_r && (ox_s || oy_s);
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_chan  = out_chan_r;
  assign x_est     = x_est_r;
  assign y_est     = y_est_r;
  assign out_rej   = out_rej_r;

  kalman_ab_axis u_axis_x (
    .clk(clk), .aresetn(aresetn),
    .pred_en(state_r == ST_PREDICT), .innov_en(state_r == ST_INNOV),
    .init_mode(!cur_init_r), .hold(gate_s),
    .p_in(px_r[cur_chan_r]), .v_in(vx_r[cur_chan_r]), .z(zx_r),
    .p_new(px_new_s), .v_new(vx_new_s), .over_gate(ox_s)
  );

  kalman_ab_axis u_axis_y (
    .clk(clk), .aresetn(aresetn),
    .pred_en(state_r == ST_PREDICT), .innov_en(state_r == ST_INNOV),
    .init_mode(!cur_init_r), .hold(gate_s),
    .p_in(py_r[cur_chan_r]), .v_in(vy_r[cur_chan_r]), .z(zy_r),
    .p_new(py_new_s), .v_new(vy_new_s), .over_gate(oy_s)
  );

`ifdef KALMAN_GATE_EN
  logic [MISS_W-1:0] miss_r [NUM_CHAN];

  assign drop_s = gate_s && (miss_r[cur_chan_r] == MISS_W'(MAX_MISS - 1));

  // Consecutive-reject count; reaching the limit drops the track and restarts the count.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_CHAN; i++) miss_r[i] <= {MISS_W{1'b0}};
    end else if (state_r == ST_UPDATE) begin
      if (gate_s && !drop_s) miss_r[cur_chan_r] <= miss_r[cur_chan_r] + MISS_W'(1);
      else miss_r[cur_chan_r] <= {MISS_W{1'b0}};
    end
  end
`else
  assign drop_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_r <= ST_IDLE;
    else state_r <= state_s;
  end

  // Next-state logic: fixed four-cycle pipeline, then wait for the consumer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:    if (accept_s) state_s = ST_PREDICT; else state_s = ST_IDLE;
      ST_PREDICT: state_s = ST_INNOV;
      ST_INNOV:   state_s = ST_UPDATE;
      ST_UPDATE:  state_s = ST_OUTPUT;
      ST_OUTPUT:  if (out_ready) state_s = ST_IDLE; else state_s = ST_OUTPUT;
      default:    state_s = ST_IDLE;
    endcase
  end

  // Input latch, channel state write-back, init bits and registered outputs.
  // kill_r remembers a clear that hit the active channel before write-back.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_chan_r  <= {CHAN_W{1'b0}};
      x_est_r     <= {DISP_WIDTH{1'b0}};
      y_est_r     <= {DISP_WIDTH{1'b0}};
      out_rej_r   <= 1'b0;
      cur_chan_r  <= {CHAN_W{1'b0}};
      zx_r        <= {DISP_WIDTH{1'b0}};
      zy_r        <= {DISP_WIDTH{1'b0}};
      cur_init_r  <= 1'b0;
      kill_r      <= 1'b0;
      init_r      <= {NUM_CHAN{1'b0}};
      for (int i = 0; i < NUM_CHAN; i++) begin
        px_r[i] <= {SW{1'b0}};
        py_r[i] <= {SW{1'b0}};
        vx_r[i] <= {SW{1'b0}};
        vy_r[i] <= {SW{1'b0}};
      end
    end else begin
      in_ready_r  <= (state_s == ST_IDLE);
      out_valid_r <= (state_s == ST_OUTPUT);
      if (accept_s) begin
        cur_chan_r <= in_chan;
        zx_r       <= z_x;
        zy_r       <= z_y;
        cur_init_r <= init_r[in_chan] && !(chan_clr && (clr_chan == in_chan));
        kill_r     <= 1'b0;
      end else if (chan_clr && (clr_chan == cur_chan_r) && (state_r != ST_IDLE)) begin
        kill_r <= 1'b1;
      end
      if (state_r == ST_UPDATE) begin
        px_r[cur_chan_r]   <= px_new_s;
        py_r[cur_chan_r]   <= py_new_s;
        vx_r[cur_chan_r]   <= vx_new_s;
        vy_r[cur_chan_r]   <= vy_new_s;
        init_r[cur_chan_r] <= !kill_r && !drop_s;
        out_chan_r         <= cur_chan_r;
        x_est_r            <= sat_to_disp(px_new_s);
        y_est_r            <= sat_to_disp(py_new_s);
        out_rej_r          <= gate_s;
      end
      if (chan_clr) init_r[clr_chan] <= 1'b0;
    end
  end

endmodule
